rotation_monitor: RTL
=====================

# rotation_monitor

Receive-side checker for the 6-bit circular shift register bus. It samples the register's parallel output every clock and classifies each change as a left rotate, a right rotate, an ambiguous rotate or a jump (preset load / corruption). It tracks direction lock, the one-hot position, step and revolution counts, and a sticky error flag. It sits on the same clock as the shift register, between its `q` bus and the board LEDs/debug logic.

## Interface
- `N`, 6: watched bus width; legal range N ≥ 3.
- `CNT_W`, 8: width of the `steps` and `revs` counters.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `clear`  in  1  synchronous; zeroes `steps`, `revs`, `err` and the revolution phase only.
- `q_in`  in  N  parallel output of the shift register, same clock domain.
- `pos`  out  $clog2(N)  index of the set bit when `onehot`=1; holds its last value otherwise.
- `onehot`  out  1  sampled word has exactly one bit set.
- `dir`  out  1  locked direction: 1 = LSB→MSB (rotate-left), 0 = MSB→LSB.
- `locked`  out  1  FSM is in LOCK_UP or LOCK_DOWN.
- `step_pulse`  out  1  one-cycle pulse per classified rotate (UP, DOWN or AMBIG).
- `jump_pulse`  out  1  one-cycle pulse per JUMP.
- `steps`  out  CNT_W  rotate-event count, wraps modulo 2^CNT_W.
- `revs`  out  CNT_W  completed revolutions, saturates at all-ones.
- `err`  out  1  sticky: a JUMP occurred while locked.

## Operation
- Pipeline: `q_s` <= `q_in`; `q_p` <= `q_s`; `primed` is set one cycle after the first `q_s` load after reset. Classification is done only when `primed`=1.
- Event classes, from `q_s` vs `q_p` (rotl/rotr are 1-bit rotates of `q_p`):
  - NONE: `q_s`==`q_p`.
  - AMBIG: `q_s`==rotl==rotr, e.g. 010101↔101010.
  - UP: `q_s`==rotl only.
  - DOWN: `q_s`==rotr only.
  - JUMP: any other change.
- FSM states: SYNC (reset state), LOCK_UP, LOCK_DOWN. Revolution phase counter `ph` runs 0..N-1.
  - SYNC + UP → LOCK_UP, `dir`=1, `ph`=1.
  - SYNC + DOWN → LOCK_DOWN, `dir`=0, `ph`=1.
  - SYNC + AMBIG → stay SYNC. SYNC + JUMP → stay SYNC; `err` is not set.
  - LOCK_x + same direction or AMBIG → `ph`+1. When `ph` reaches N: `revs`+1 (saturating) and `ph`=0.
  - LOCK_UP + DOWN, or LOCK_DOWN + UP → switch to the opposite lock, update `dir`, `ph`=1, `revs` unchanged.
  - LOCK_x + JUMP → SYNC, `err`=1, `ph`=0; `dir` holds.
  - NONE → no change in any state.
- `step_pulse`=1 and `steps`+1 for UP, DOWN and AMBIG in every state. `jump_pulse`=1 for JUMP in every state.
- `onehot`/`pos` are derived from `q_s`. `pos` updates only when `onehot`=1.
- `clear` in the same cycle as an event:
  - FSM transition and pulses proceed normally.
  - `steps`, `revs`, `err`, `ph` end at 0; clear wins.
- `reset` has priority over everything.

## Timing
- Reset values: `pos`=0, `onehot`=0, `dir`=0, `locked`=0, `step_pulse`=0, `jump_pulse`=0, `steps`=0, `revs`=0, `err`=0. Internal: `q_s`=`q_p`=0, `primed`=0, `ph`=0, state SYNC.
- Latency: a new `q_in` value captured at edge k is visible on `onehot`/`pos` after edge k+1. Its event (pulses, counters, `locked`, `dir`, `err`) is visible after edge k+1.
- Pulses are exactly 1 cycle wide. Back-to-back changes on consecutive cycles each produce their own pulse.
- The first `q_s` value after reset is never classified; a nonzero word after reset does not produce a JUMP.
- Mid-operation reset: all outputs return to reset values at the next edge, and the following word is treated as first-after-reset.

## Test plan
- Reset, then hold `q_in`=000001 → after 2 edges `onehot`=1, `pos`=0, `locked`=0, no pulses.
- Rotate-left one step per 3 cycles, 000001→000010→…→100000→000001 → 6 `step_pulse`, `locked`=1, `dir`=1, `steps`=6, `revs`=1.
- While LOCK_UP at 000100, present 000010 → LOCK_DOWN, `dir`=0, `revs` unchanged. Then present 001100 (preset load) → `jump_pulse`, `locked`=0, `err`=1, `onehot`=0, `pos` holds 1.
- In SYNC, alternate 010101↔101010 for 4 changes → 4 `step_pulse`, `steps`=4, `locked`=0, `dir` unchanged.
- With `CNT_W`=3, drive 9 up steps → `steps`=1 (wrap). Drive 48 up steps → `revs` saturates at 7.
- Assert `clear` on the same cycle as an UP event with `err`=1 → `step_pulse`=1, `steps`=0, `revs`=0, `err`=0. Assert `reset` mid-rotation → all outputs at reset values.

Source files
------------

// File: rtl/rotation_monitor.sv
// Receive-side checker for a circular shift register bus.
// Classifies each word change as rotate, ambiguous rotate or jump.
module rotation_monitor #(
  parameter int N     = 6,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [N-1:0]         q_in,
  output logic [$clog2(N)-1:0] pos,
  output logic                 onehot,
  output logic                 dir,
  output logic                 locked,
  output logic                 step_pulse,
  output logic                 jump_pulse,
  output logic [CNT_W-1:0]     steps,
  output logic [CNT_W-1:0]     revs,
  output logic                 err
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    SYNC,
    LOCK_UP,
    LOCK_DOWN
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]  q_s, q_p;
  logic [N-1:0]  rotl, rotr;
  logic          loaded, primed;
  logic          eq, ml, mr;
  logic          ev_up, ev_dn, ev_amb, ev_jmp;
  logic          ev_step;
  logic [PW-1:0] ph, ph_nx, ph_inc;
  logic [PW-1:0] pos_nx;
  logic          ph_wrap;
  logic          dir_nx, rev_inc, err_set;

  assign rotl = {q_p[N-2:0], q_p[N-1]};
  assign rotr = {q_p[0], q_p[N-1:1]};
  assign eq   = (q_s == q_p);
  assign ml   = (q_s == rotl);
  assign mr   = (q_s == rotr);

  always_comb begin
    ev_up  = 1'b0;
    ev_dn  = 1'b0;
    ev_amb = 1'b0;
    ev_jmp = 1'b0;
    if (primed) begin
      unique case (1'b1)
        eq:                ev_jmp = 1'b0;
        (!eq && ml && mr):  ev_amb = 1'b1;
        (!eq && ml && !mr): ev_up  = 1'b1;
        (!eq && !ml && mr): ev_dn  = 1'b1;
        default:           ev_jmp = 1'b1;
      endcase
    end
  end

  assign ev_step = ev_up | ev_dn | ev_amb;
  assign ph_wrap = (ph == PW'(N - 1));
  assign ph_inc  = ph_wrap ? '0 : ph + PW'(1);
  assign locked  = (state != SYNC);

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    ph_nx    = ph;
    rev_inc  = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      SYNC: begin
        if (ev_up) begin
          state_nx = LOCK_UP;
          dir_nx   = 1'b1;
          ph_nx    = PW'(1);
        end else if (ev_dn) begin
          state_nx = LOCK_DOWN;
          dir_nx   = 1'b0;
          ph_nx    = PW'(1);
        end
      end
      LOCK_UP: begin
        if (ev_up || ev_amb) begin
          ph_nx   = ph_inc;
          rev_inc = ph_wrap;
        end else if (ev_dn) begin
          state_nx = LOCK_DOWN;
          dir_nx   = 1'b0;
          ph_nx    = PW'(1);
        end else if (ev_jmp) begin
          state_nx = SYNC;
          err_set  = 1'b1;
          ph_nx    = '0;
        end
      end
      LOCK_DOWN: begin
        if (ev_dn || ev_amb) begin
          ph_nx   = ph_inc;
          rev_inc = ph_wrap;
        end else if (ev_up) begin
          state_nx = LOCK_UP;
          dir_nx   = 1'b1;
          ph_nx    = PW'(1);
        end else if (ev_jmp) begin
          state_nx = SYNC;
          err_set  = 1'b1;
          ph_nx    = '0;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  always_comb begin
    pos_nx = '0;
    for (int i = 0; i < N; i++) begin
      if (q_s[i]) pos_nx = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_s        <= '0;
      q_p        <= '0;
      loaded     <= 1'b0;
      primed     <= 1'b0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      jump_pulse <= 1'b0;
      onehot     <= 1'b0;
      pos        <= '0;
      steps      <= '0;
      revs       <= '0;
      err        <= 1'b0;
      ph         <= '0;
    end else begin
      q_s        <= q_in;
      q_p        <= q_s;
      loaded     <= 1'b1;
      primed     <= loaded;
      dir        <= dir_nx;
      step_pulse <= ev_step;
      jump_pulse <= ev_jmp;
      onehot     <= $onehot(q_s);
      if ($onehot(q_s)) pos <= pos_nx;
      // clear overrides the counters but not the FSM move
      if (clear) begin
        steps <= '0;
        revs  <= '0;
        err   <= 1'b0;
        ph    <= '0;
      end else begin
        if (ev_step) steps <= steps + CNT_W'(1);
        if (rev_inc && revs != '1) revs <= revs + CNT_W'(1);
        if (err_set) err <= 1'b1;
        ph <= ph_nx;
      end
    end
  end

endmodule
